// File: rtl/macc_if.sv
// macc_if: load/drain enables and per-lane data for the macc staging buffer
interface macc_if #(parameter int WIDTH = 32);
  logic [2:0] wen;
  logic [2:0] ren;
  logic [WIDTH-1:0] matrix_a_in;
  logic [WIDTH-1:0] matrix_b_in;
  logic [WIDTH-1:0] matrix_c_in;
  logic [WIDTH-1:0] matrix_a_out;
  logic [WIDTH-1:0] matrix_b_out;
  logic [WIDTH-1:0] matrix_c_out;
  modport master (
    output wen, ren, matrix_a_in, matrix_b_in, matrix_c_in,
    input  matrix_a_out, matrix_b_out, matrix_c_out
  );
  modport slave (
    input  wen, ren, matrix_a_in, matrix_b_in, matrix_c_in,
    output matrix_a_out, matrix_b_out, matrix_c_out
  );
endinterface

// File: rtl/macc.sv
// macc: three independent shift-chain staging lanes (A, B, C) with zero-filling drain
module macc #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input logic   CLK,
  input logic   RST_L,
  macc_if.slave bus
);
  logic [WIDTH-1:0] in_w    [3];
  logic [WIDTH-1:0] stage_q [3][DEPTH];
  logic [WIDTH-1:0] stage_d [3][DEPTH];
  assign in_w[2] = bus.matrix_a_in;
  assign in_w[1] = bus.matrix_b_in;
  assign in_w[0] = bus.matrix_c_in;
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      stage_d[k][0] = (bus.wen[k] | bus.ren[k]) ? (bus.wen[k] ? in_w[k] : '0) : stage_q[k][0];
      for (int i = 1; i < DEPTH; i++)
        stage_d[k][i] = (bus.wen[k] | bus.ren[k]) ? stage_q[k][i-1] : stage_q[k][i];
    end
  end
  always_ff @(posedge CLK) begin
    if (!RST_L) stage_q <= '{default: '0};
    else stage_q <= stage_d;
  end
  assign bus.matrix_a_out = stage_q[2][DEPTH-1];
  assign bus.matrix_b_out = stage_q[1][DEPTH-1];
  assign bus.matrix_c_out = stage_q[0][DEPTH-1];
endmodule

// File: tb/tb_macc.sv
// tb_macc: directed self-checking bench for the macc staging buffer (DEPTH=2)
module tb_macc;
  logic clk = 0;
  logic rst_l;
  int checks = 0;
  int errors = 0;
  macc_if #(.WIDTH(32)) bus ();
  macc #(.WIDTH(32), .DEPTH(2)) dut (.CLK(clk), .RST_L(rst_l), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [2:0] w, input logic [2:0] r,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    bus.wen = w;
    bus.ren = r;
    bus.matrix_a_in = a;
    bus.matrix_b_in = b;
    bus.matrix_c_in = c;
  endtask
  task automatic test_reset();
    rst_l = 0;
    drive(3'($urandom), 3'($urandom), $urandom, $urandom, $urandom);
    step();
    drive(3'($urandom), 3'($urandom), $urandom, $urandom, $urandom);
    step();
    checks++; if (bus.matrix_a_out !== 32'h0) begin errors++; $display("FAIL reset_a got %h exp %h", bus.matrix_a_out, 32'h0); end
    checks++; if (bus.matrix_b_out !== 32'h0) begin errors++; $display("FAIL reset_b got %h exp %h", bus.matrix_b_out, 32'h0); end
    checks++; if (bus.matrix_c_out !== 32'h0) begin errors++; $display("FAIL reset_c got %h exp %h", bus.matrix_c_out, 32'h0); end
    rst_l = 1;
    drive(3'b000, 3'b000, 32'hffffffff, 32'hffffffff, 32'hffffffff);
    step();
    step();
    checks++; if (bus.matrix_a_out !== 32'h0) begin errors++; $display("FAIL idle_a got %h exp %h", bus.matrix_a_out, 32'h0); end
    checks++; if (bus.matrix_b_out !== 32'h0) begin errors++; $display("FAIL idle_b got %h exp %h", bus.matrix_b_out, 32'h0); end
    checks++; if (bus.matrix_c_out !== 32'h0) begin errors++; $display("FAIL idle_c got %h exp %h", bus.matrix_c_out, 32'h0); end
  endtask
  task automatic test_load_hold_drain();
    drive(3'b100, 3'b000, 32'hdeadbeef, 0, 0);
    step();
    drive(3'b000, 3'b000, 32'ha5a5a5a5, 0, 0);
    step();
    checks++; if (bus.matrix_a_out !== 32'h0) begin errors++; $display("FAIL hold_a got %h exp %h", bus.matrix_a_out, 32'h0); end
    drive(3'b100, 3'b000, 32'hfeed2b0b, 0, 0);
    step();
    checks++; if (bus.matrix_a_out !== 32'hdeadbeef) begin errors++; $display("FAIL load1_a got %h exp %h", bus.matrix_a_out, 32'hdeadbeef); end
    drive(3'b100, 3'b000, 32'h00000001, 0, 0);
    step();
    checks++; if (bus.matrix_a_out !== 32'hfeed2b0b) begin errors++; $display("FAIL load2_a got %h exp %h", bus.matrix_a_out, 32'hfeed2b0b); end
    drive(3'b000, 3'b100, 32'h77777777, 0, 0);
    step();
    checks++; if (bus.matrix_a_out !== 32'h00000001) begin errors++; $display("FAIL drain1_a got %h exp %h", bus.matrix_a_out, 32'h00000001); end
    step();
    checks++; if (bus.matrix_a_out !== 32'h0) begin errors++; $display("FAIL drain2_a got %h exp %h", bus.matrix_a_out, 32'h0); end
    drive(3'b000, 3'b000, 0, 0, 0);
  endtask
  task automatic test_independence();
    drive(3'b100, 3'b000, 32'h12345678, 0, 0);
    step();
    drive(3'b100, 3'b000, 32'h9abcdef0, 0, 0);
    step();
    drive(3'b010, 3'b000, 32'hcccccccc, 32'h11111111, 32'hcccccccc);
    step();
    drive(3'b001, 3'b000, 32'hcccccccc, 32'hdddddddd, 32'h33333333);
    step();
    drive(3'b010, 3'b000, 32'hcccccccc, 32'h22222222, 32'heeeeeeee);
    step();
    drive(3'b001, 3'b000, 32'hcccccccc, 32'hdddddddd, 32'h44444444);
    step();
    checks++; if (bus.matrix_b_out !== 32'h11111111) begin errors++; $display("FAIL indep_b got %h exp %h", bus.matrix_b_out, 32'h11111111); end
    checks++; if (bus.matrix_c_out !== 32'h33333333) begin errors++; $display("FAIL indep_c got %h exp %h", bus.matrix_c_out, 32'h33333333); end
    checks++; if (bus.matrix_a_out !== 32'h12345678) begin errors++; $display("FAIL indep_a got %h exp %h", bus.matrix_a_out, 32'h12345678); end
    drive(3'b000, 3'b000, 0, 0, 0);
  endtask
  task automatic test_simultaneous();
    drive(3'b010, 3'b000, 0, 32'haaaaaaaa, 0);
    step();
    drive(3'b010, 3'b010, 0, 32'hbbbbbbbb, 0);
    step();
    checks++; if (bus.matrix_b_out !== 32'haaaaaaaa) begin errors++; $display("FAIL wr_rd_b got %h exp %h", bus.matrix_b_out, 32'haaaaaaaa); end
    drive(3'b000, 3'b010, 0, 32'h55555555, 0);
    step();
    checks++; if (bus.matrix_b_out !== 32'hbbbbbbbb) begin errors++; $display("FAIL wr_rd_drain_b got %h exp %h", bus.matrix_b_out, 32'hbbbbbbbb); end
    checks++; if (bus.matrix_c_out !== 32'h33333333) begin errors++; $display("FAIL drain_b_keeps_c got %h exp %h", bus.matrix_c_out, 32'h33333333); end
    drive(3'b000, 3'b000, 0, 0, 0);
  endtask
  task automatic test_overflow();
    drive(3'b001, 3'b000, 0, 0, 32'h1);
    step();
    drive(3'b001, 3'b000, 0, 0, 32'h2);
    step();
    drive(3'b001, 3'b000, 0, 0, 32'h3);
    step();
    checks++; if (bus.matrix_c_out !== 32'h2) begin errors++; $display("FAIL ovf_c got %h exp %h", bus.matrix_c_out, 32'h2); end
    drive(3'b000, 3'b001, 0, 0, 0);
    step();
    checks++; if (bus.matrix_c_out !== 32'h3) begin errors++; $display("FAIL ovf_drain1_c got %h exp %h", bus.matrix_c_out, 32'h3); end
    step();
    checks++; if (bus.matrix_c_out !== 32'h0) begin errors++; $display("FAIL ovf_drain2_c got %h exp %h", bus.matrix_c_out, 32'h0); end
    drive(3'b000, 3'b000, 0, 0, 0);
  endtask
  task automatic test_reset_mid();
    drive(3'b111, 3'b000, 32'ha1a1a1a1, 32'hb1b1b1b1, 32'hc1c1c1c1);
    step();
    drive(3'b111, 3'b000, 32'ha2a2a2a2, 32'hb2b2b2b2, 32'hc2c2c2c2);
    step();
    checks++; if (bus.matrix_a_out !== 32'ha1a1a1a1) begin errors++; $display("FAIL preload_a got %h exp %h", bus.matrix_a_out, 32'ha1a1a1a1); end
    rst_l = 0;
    drive(3'b111, 3'b111, 32'ha3a3a3a3, 32'hb3b3b3b3, 32'hc3c3c3c3);
    step();
    rst_l = 1;
    drive(3'b000, 3'b000, 0, 0, 0);
    checks++; if (bus.matrix_a_out !== 32'h0) begin errors++; $display("FAIL midrst_a got %h exp %h", bus.matrix_a_out, 32'h0); end
    checks++; if (bus.matrix_b_out !== 32'h0) begin errors++; $display("FAIL midrst_b got %h exp %h", bus.matrix_b_out, 32'h0); end
    checks++; if (bus.matrix_c_out !== 32'h0) begin errors++; $display("FAIL midrst_c got %h exp %h", bus.matrix_c_out, 32'h0); end
    drive(3'b000, 3'b111, 0, 0, 0);
    step();
    checks++; if (bus.matrix_a_out !== 32'h0) begin errors++; $display("FAIL rstdrain_a got %h exp %h", bus.matrix_a_out, 32'h0); end
    checks++; if (bus.matrix_b_out !== 32'h0) begin errors++; $display("FAIL rstdrain_b got %h exp %h", bus.matrix_b_out, 32'h0); end
    checks++; if (bus.matrix_c_out !== 32'h0) begin errors++; $display("FAIL rstdrain_c got %h exp %h", bus.matrix_c_out, 32'h0); end
    drive(3'b000, 3'b000, 0, 0, 0);
  endtask
  initial begin
    rst_l = 0;
    drive(3'b000, 3'b000, 0, 0, 0);
    test_reset();
    test_load_hold_drain();
    test_independence();
    test_simultaneous();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
